// File: rtl/fifo_cycle_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_cycle_pkg
//  Purpose  : Shared definitions for the parametrised cycle FIFO: read-mode
//             selector constants and a constant clog2 function used to size
//             pointers and the occupancy counter.
//  Ports    : none (package)
//  Revision : 1.0 - initial parametrised release
// ============================================================================
package fifo_cycle_pkg;

   localparam int FIFO_MODE_REG  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   // Smallest r with 2**r >= value; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_cycle_mem.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_cycle_mem
//  Purpose  : DATA_WIDTH x DEPTH storage array with one synchronous write
//             port and one asynchronous read port. Contents are not reset.
//  Ports    : clock          - write clock
//             write_enable   - store write_data at write_address on the edge
//             write_address  - write location
//             write_data     - write value
//             read_address   - read location
//             read_data      - combinational contents of read_address
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module fifo_cycle_mem
   import fifo_cycle_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 64,
   parameter int ADDR_WIDTH = clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_address,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] read_address,
   output logic [DATA_WIDTH-1:0] read_data
);

   logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

   always_ff @(posedge clock) begin
      if (write_enable) r_mem[write_address] <= write_data;
   end

   assign read_data = r_mem[read_address];

endmodule
`default_nettype wire

// File: rtl/fifo_cycle_param.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_cycle_param
//  Purpose  : Single-clock synchronous FIFO of arbitrary DEPTH with selectable
//             registered / first-word-fall-through read, programmable
//             almost-full / almost-empty thresholds, fill level and
//             overflow / underflow pulses.
//  Macro    : FIFO_CYCLE_WATERMARK_EN - adds peak_level / watermark_clear.
//  Ports    : clock, reset (async active-low)
//             buffer_in, write_enable, read_enable -> buffer_out
//             buffer_full, buffer_empty, almost_full, almost_empty, fill_level
//             overflow / underflow (one-cycle pulses after a rejected request)
//             [peak_level, watermark_clear when the macro is defined]
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module fifo_cycle_param
   import fifo_cycle_pkg::*;
#(
   parameter  int DATA_WIDTH = 8,
   parameter  int DEPTH      = 64,
   parameter  int FWFT       = FIFO_MODE_REG,
   parameter  int AF_THRESH  = DEPTH - 2,
   parameter  int AE_THRESH  = 2,
   localparam int ADDR_WIDTH = clog2(DEPTH),
   localparam int CNT_WIDTH  = clog2(DEPTH + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] buffer_in,
   input  logic                  write_enable,
   input  logic                  read_enable,
   output logic [DATA_WIDTH-1:0] buffer_out,
   output logic                  buffer_full,
   output logic                  buffer_empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CNT_WIDTH-1:0]  fill_level,
   output logic                  overflow,
   output logic                  underflow
`ifdef FIFO_CYCLE_WATERMARK_EN
   ,
   input  logic                  watermark_clear,
   output logic [CNT_WIDTH-1:0]  peak_level
`endif
);

   localparam logic [CNT_WIDTH-1:0]  c_full_cnt = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0]  c_af       = CNT_WIDTH'(AF_THRESH);
   localparam logic [CNT_WIDTH-1:0]  c_ae       = CNT_WIDTH'(AE_THRESH);
   localparam logic [ADDR_WIDTH-1:0] c_ptr_last = ADDR_WIDTH'(DEPTH - 1);

   generate
      if (DEPTH < 2 || AF_THRESH > DEPTH || AE_THRESH >= AF_THRESH) begin : g_bad_cfg
         $error("fifo_cycle_param: need DEPTH>=2, AF_THRESH<=DEPTH, AE_THRESH<AF_THRESH");
      end
   endgenerate

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [CNT_WIDTH-1:0]  r_fill;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_acc;
   logic                  w_rd_acc;

   assign w_full   = (r_fill == c_full_cnt);
   assign w_empty  = (r_fill == '0);
   assign w_wr_acc = write_enable & ~w_full;
   assign w_rd_acc = read_enable & ~w_empty;

   assign buffer_full  = w_full;
   assign buffer_empty = w_empty;
   assign almost_full  = (r_fill >= c_af);
   assign almost_empty = (r_fill <= c_ae);
   assign fill_level   = r_fill;

   fifo_cycle_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clock         (clock),
      .write_enable  (w_wr_acc),
      .write_address (r_wr_ptr),
      .write_data    (buffer_in),
      .read_address  (r_rd_ptr),
      .read_data     (w_rd_data)
   );

   // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_fill    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
         if (w_rd_acc) r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_fill <= r_fill + 1'b1;
            2'b01:   r_fill <= r_fill - 1'b1;
            default: r_fill <= r_fill;
         endcase
         overflow  <= write_enable & w_full;
         underflow <= read_enable & w_empty;
      end
   end

   generate
      if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
         // Head word is shown directly; zero while there is nothing to show.
         assign buffer_out = w_empty ? '0 : w_rd_data;
      end else begin : g_reg
         always_ff @(posedge clock or negedge reset) begin
            if (!reset)        buffer_out <= '0;
            else if (w_rd_acc) buffer_out <= w_rd_data;
         end
      end
   endgenerate

`ifdef FIFO_CYCLE_WATERMARK_EN
   // Clear has priority: it re-seeds the watermark from the present level.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                  peak_level <= '0;
      else if (watermark_clear)    peak_level <= r_fill;
      else if (r_fill > peak_level) peak_level <= r_fill;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_cycle_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_cycle_param
//  Purpose  : Self-checking bench for fifo_cycle_param. Two instances share
//             stimulus: A = DEPTH 5 registered read, B = DEPTH 8 FWFT with
//             AF 6 / AE 2. A queue-based reference model predicts outputs.
//  Revision : 1.0 - initial
// ============================================================================
module tb_fifo_cycle_param;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] buffer_in = '0;
   logic       write_enable = 1'b0;
   logic       read_enable = 1'b0;
   logic       watermark_clear = 1'b0;

   logic [7:0] out_a, out_b;
   logic       full_a, full_b, empty_a, empty_b;
   logic       af_a, af_b, ae_a, ae_b;
   logic       ovf_a, ovf_b, udf_a, udf_b;
   logic [2:0] fl_a;
   logic [3:0] fl_b;
   logic [2:0] pk_a;
   logic [3:0] pk_b;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   fifo_cycle_param #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) u_a (
      .clock(clock), .reset(reset), .buffer_in(buffer_in),
      .write_enable(write_enable), .read_enable(read_enable),
      .buffer_out(out_a), .buffer_full(full_a), .buffer_empty(empty_a),
      .almost_full(af_a), .almost_empty(ae_a), .fill_level(fl_a),
      .overflow(ovf_a), .underflow(udf_a)
`ifdef FIFO_CYCLE_WATERMARK_EN
      , .watermark_clear(watermark_clear), .peak_level(pk_a)
`endif
   );

   fifo_cycle_param #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(2)) u_b (
      .clock(clock), .reset(reset), .buffer_in(buffer_in),
      .write_enable(write_enable), .read_enable(read_enable),
      .buffer_out(out_b), .buffer_full(full_b), .buffer_empty(empty_b),
      .almost_full(af_b), .almost_empty(ae_b), .fill_level(fl_b),
      .overflow(ovf_b), .underflow(udf_b)
`ifdef FIFO_CYCLE_WATERMARK_EN
      , .watermark_clear(watermark_clear), .peak_level(pk_b)
`endif
   );

`ifndef FIFO_CYCLE_WATERMARK_EN
   assign pk_a = '0;
   assign pk_b = '0;
`endif

   // ---------------- reference model ----------------
   int         depth [2] = '{5, 8};
   int         af    [2] = '{3, 6};
   int         ae    [2] = '{2, 2};
   bit         fwft  [2] = '{1'b0, 1'b1};
   logic [7:0] qa [$];
   logic [7:0] qb [$];
   logic [7:0] m_out  [2];
   bit         m_ovf  [2];
   bit         m_udf  [2];
   int         m_peak [2];

   function automatic int qsize(input int k);
      return (k == 0) ? qa.size() : qb.size();
   endfunction

   function automatic logic [7:0] qfront(input int k);
      return (k == 0) ? qa[0] : qb[0];
   endfunction

   task automatic model_reset();
      qa.delete();
      qb.delete();
      for (int k = 0; k < 2; k++) begin
         m_out[k] = '0; m_ovf[k] = 0; m_udf[k] = 0; m_peak[k] = 0;
      end
   endtask

   task automatic model_step(input bit we, input bit re, input logic [7:0] d, input bit clr);
      for (int k = 0; k < 2; k++) begin
         int         fill;
         bit         full, empty;
         logic [7:0] v;
         fill  = qsize(k);
         full  = (fill == depth[k]);
         empty = (fill == 0);
         m_ovf[k]  = we && full;
         m_udf[k]  = re && empty;
         m_peak[k] = clr ? fill : ((fill > m_peak[k]) ? fill : m_peak[k]);
         if (re && !empty) begin
            if (k == 0) v = qa.pop_front();
            else        v = qb.pop_front();
            if (!fwft[k]) m_out[k] = v;
         end
         if (we && !full) begin
            if (k == 0) qa.push_back(d);
            else        qb.push_back(d);
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_inst(input int k, input int o_fill, input int o_full, input int o_empty,
                             input int o_af, input int o_ae, input int o_out,
                             input int o_ovf, input int o_udf, input int o_peak);
      int    fill;
      int    e_out;
      string nm;
      nm    = (k == 0) ? "A" : "B";
      fill  = qsize(k);
      e_out = fwft[k] ? ((fill == 0) ? 0 : int'(qfront(k))) : int'(m_out[k]);
      chk({nm, ".fill"},  o_fill,  fill);
      chk({nm, ".full"},  o_full,  int'(fill == depth[k]));
      chk({nm, ".empty"}, o_empty, int'(fill == 0));
      chk({nm, ".afull"}, o_af,    int'(fill >= af[k]));
      chk({nm, ".aempty"},o_ae,    int'(fill <= ae[k]));
      chk({nm, ".out"},   o_out,   e_out);
      chk({nm, ".ovf"},   o_ovf,   int'(m_ovf[k]));
      chk({nm, ".udf"},   o_udf,   int'(m_udf[k]));
`ifdef FIFO_CYCLE_WATERMARK_EN
      chk({nm, ".peak"},  o_peak,  m_peak[k]);
`endif
   endtask

   task automatic check_all();
      check_inst(0, int'(fl_a), int'(full_a), int'(empty_a), int'(af_a), int'(ae_a),
                 int'(out_a), int'(ovf_a), int'(udf_a), int'(pk_a));
      check_inst(1, int'(fl_b), int'(full_b), int'(empty_b), int'(af_b), int'(ae_b),
                 int'(out_b), int'(ovf_b), int'(udf_b), int'(pk_b));
   endtask

   // One clock: drive, let the edge happen, advance the model, then check.
   task automatic cyc(input bit we, input bit re, input logic [7:0] d, input bit clr);
      write_enable    = we;
      read_enable     = re;
      buffer_in       = d;
      watermark_clear = clr;
      @(posedge clock);
      model_step(we, re, d, clr);
      #1;
      write_enable    = 1'b0;
      read_enable     = 1'b0;
      watermark_clear = 1'b0;
      check_all();
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_all();
      reset = 1'b1;

      // Ordered write/read through the depth-5 instance.
      for (int i = 1; i <= 5; i++) cyc(1, 0, 8'(i * 8'h11), 0);
      for (int i = 0; i < 5; i++)  cyc(0, 1, 8'h00, 0);

      // Pointer wrap: three rounds of write 4 / read 4.
      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j < 4; j++) cyc(1, 0, 8'(8'h60 + r * 16 + j), 0);
         for (int j = 0; j < 4; j++) cyc(0, 1, 8'h00, 0);
      end

      // Full + write + read, then drain.
      for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'hC0 + i), 0);
      cyc(1, 1, 8'hEE, 0);
      cyc(0, 0, 8'h00, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1, 8'h00, 0);

      // Empty + write + read, then empty again.
      cyc(1, 1, 8'h3C, 0);
      cyc(0, 0, 8'h00, 0);
      cyc(0, 1, 8'h00, 0);

      // Fall-through of a single word into an empty FIFO.
      cyc(1, 0, 8'hA5, 0);
      cyc(0, 0, 8'h00, 0);
      cyc(0, 1, 8'h00, 0);

      // Threshold sweep on the depth-8 instance: fill to 8, drain to 0.
      for (int i = 0; i < 8; i++) cyc(1, 0, 8'(8'h80 + i), 0);
      for (int i = 0; i < 8; i++) cyc(0, 1, 8'h00, 0);

      // Asynchronous reset in the middle of a fill.
      for (int i = 0; i < 3; i++) cyc(1, 0, 8'(8'h90 + i), 0);
      cyc(0, 1, 8'h00, 0);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clock);
      #1;
      reset = 1'b1;
      check_all();

      // Randomised traffic with alternating write-heavy / read-heavy phases.
      for (int i = 0; i < 800; i++) begin
         int bias;
         bias = ((i / 40) % 2 == 0) ? 75 : 25;
         cyc($urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias),
             8'($urandom), $urandom_range(0, 19) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
